// File: rtl/i2s_master_ctrl.sv
// i2s_master_ctrl: I2S bus-master clock/frame sequencer.
// Derives SCLK and LRCK from clk_in through a run-time divider, emits
// system-clock-domain strobes for SCLK edges and frame starts, and counts
// frames. Starting and stopping only happen on frame boundaries, so a
// receiver never sees a partial frame.
module i2s_master_ctrl #(
  parameter int DIV_WIDTH  = 8,
  parameter int SLOT_BITS  = 32,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  enable_in,
  input  logic [DIV_WIDTH-1:0]  div_in,
  output logic                  sclk_out,
  output logic                  lrck_out,
  output logic                  sclk_rise_out,
  output logic                  sclk_fall_out,
  output logic                  frame_start_out,
  output logic                  running_out,
  output logic [FCNT_WIDTH-1:0] frame_cnt_out
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_lat_q, div_lat_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]         bit_nxt;
  logic                  sclk_q, sclk_d;
  logic                  lrck_q, lrck_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic                  fs_q, fs_d;
  logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;

  assign bit_nxt = bit_cnt_q + 1'b1;

  // Register the whole sequencer state; reset returns to IDLE immediately.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values and updates together.
      state_q   <= IDLE;
      div_lat_q <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      lrck_q    <= 1'b1;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      fs_q      <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_lat_q <= div_lat_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      lrck_q    <= lrck_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      fs_q      <= fs_d;
      fcnt_q    <= fcnt_d;
    end
  end

  // Next-state logic: frame start from IDLE, divider, bit counter, boundary.
  always_comb begin
    // NOTE: every value written here gets a default first, so no path through
    // the case statement can infer a latch; strobes default low.
    state_d   = state_q;
    div_lat_d = div_lat_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    lrck_d    = lrck_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    fs_d      = 1'b0;
    fcnt_d    = fcnt_q;

    case (state_q)
      IDLE: begin
        if (enable_in) begin
          state_d   = RUN;
          div_lat_d = div_in;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          sclk_d    = 1'b0;
          lrck_d    = 1'b0;
          fs_d      = 1'b1;
          fcnt_d    = fcnt_q + 1'b1;
        end
      end

      default: begin
        // Away from a boundary, enable only moves us between RUN and STOP.
        if (state_q == RUN && !enable_in) begin
          state_d = STOP;
        end else if (state_q == STOP && enable_in) begin
          state_d = RUN;
        end

        if (div_cnt_q == div_lat_q) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          if (!sclk_q) begin
            rise_d = 1'b1;
          end else begin
            fall_d = 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              // Frame boundary: either start the next frame or park in IDLE.
              bit_cnt_d = '0;
              if (state_q == RUN && enable_in) begin
                state_d   = RUN;
                lrck_d    = 1'b0;
                fs_d      = 1'b1;
                fcnt_d    = fcnt_q + 1'b1;
                div_lat_d = div_in;
              end else begin
                state_d = IDLE;
                sclk_d  = 1'b0;
                lrck_d  = 1'b1;
                fall_d  = 1'b0;
              end
            end else begin
              bit_cnt_d = bit_nxt;
              lrck_d    = (int'(bit_nxt) >= SLOT_BITS);
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign sclk_out        = sclk_q;
  assign lrck_out        = lrck_q;
  assign sclk_rise_out   = rise_q;
  assign sclk_fall_out   = fall_q;
  assign frame_start_out = fs_q;
  assign running_out     = (state_q != IDLE);
  assign frame_cnt_out   = fcnt_q;

endmodule

// File: tb/tb_i2s_master_ctrl.sv
// Testbench for i2s_master_ctrl: scoreboard against a frame-position model,
// plus an I2S loopback through a bench-side serial source and receiver.
module tb_i2s_master_ctrl;

  localparam int SLOT = 4;
  localparam logic [31:0] WORD_L = 32'hA5A5_0F0F;
  localparam logic [31:0] WORD_R = 32'h1234_5678;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [7:0]  div;
  logic        sclk, lrck, rise, fall, fs, running;
  logic [15:0] fcnt;

  logic        rst2;
  logic        sclk2, lrck2, rise2, fall2, fs2, running2;
  logic [15:0] fcnt2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        sclk;
    logic        lrck;
    logic        rise;
    logic        fall;
    logic        fs;
    logic        run;
    logic [15:0] fc;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_exp;
  obs_t mon_got;

  // Model state: position inside the current frame in clk cycles.
  bit          m_active = 0;
  bit          m_fresh  = 0;
  bit          m_stop   = 0;
  int          m_t      = 0;
  int          m_h      = 1;
  logic [15:0] m_fc     = '0;

  i2s_master_ctrl #(.DIV_WIDTH(8), .SLOT_BITS(SLOT), .FCNT_WIDTH(16)) u_dut (
    .clk_in(clk), .rst_in(rst), .enable_in(enable), .div_in(div),
    .sclk_out(sclk), .lrck_out(lrck), .sclk_rise_out(rise),
    .sclk_fall_out(fall), .frame_start_out(fs), .running_out(running),
    .frame_cnt_out(fcnt)
  );

  i2s_master_ctrl #(.DIV_WIDTH(8), .SLOT_BITS(32), .FCNT_WIDTH(16)) u_lb (
    .clk_in(clk), .rst_in(rst2), .enable_in(1'b1), .div_in(8'd3),
    .sclk_out(sclk2), .lrck_out(lrck2), .sclk_rise_out(rise2),
    .sclk_fall_out(fall2), .frame_start_out(fs2), .running_out(running2),
    .frame_cnt_out(fcnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  function automatic obs_t idle_obs();
    obs_t o;
    o = '{sclk: 1'b0, lrck: 1'b1, rise: 1'b0, fall: 1'b0, fs: 1'b0,
          run: 1'b0, fc: m_fc};
    return o;
  endfunction

  // Reference: advance one clk edge with the inputs seen at that edge and
  // return the outputs expected after it. Outputs are derived purely from
  // the position t inside the frame and the half-period h.
  function automatic obs_t model_edge(input bit en, input int d);
    obs_t o;
    int   ph;
    bit   on_edge;
    if (!m_active) begin
      if (en) begin
        m_active = 1; m_t = 0; m_h = d + 1; m_fc = m_fc + 16'd1;
        m_fresh = 1; m_stop = 0;
      end
    end else begin
      m_t++;
      if (m_t == 4 * SLOT * m_h) begin
        if (m_stop || !en) begin
          m_active = 0;
        end else begin
          m_t = 0; m_h = d + 1; m_fc = m_fc + 16'd1; m_fresh = 0; m_stop = 0;
        end
      end else begin
        m_stop = !en;
      end
    end
    if (!m_active) return idle_obs();
    ph      = m_t / m_h;
    on_edge = (m_t % m_h) == 0;
    o.sclk = ph[0];
    o.lrck = (m_t / (2 * m_h)) >= SLOT;
    o.rise = on_edge && ph[0];
    o.fall = on_edge && !ph[0] && !(m_t == 0 && m_fresh);
    o.fs   = (m_t == 0);
    o.run  = 1'b1;
    o.fc   = m_fc;
    return o;
  endfunction

  task automatic tick(input bit en, input int d);
    enable = en;
    div    = d[7:0];
    @(posedge clk);
    exp_q.push_back(model_edge(en, d));
    @(negedge clk);
  endtask

  // Monitor: one expected vector per clk edge, compared on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = '{sclk: sclk, lrck: lrck, rise: rise, fall: fall, fs: fs,
                  run: running, fc: fcnt};
      check("outputs", 64'(mon_got), 64'(mon_exp));
    end
  end

  // Loopback: serial source driven on SCLK falls, receiver sampling on rises.
  logic [32:0] lb_q[$];
  logic [32:0] lb_exp;
  logic [31:0] tx_sh = '0;
  logic [31:0] rx_sh = '0;
  logic        sd = 1'b0;
  logic        tx_prev = 1'b0;
  logic        rx_prev = 1'b0;
  int          lb_words = 0;

  always @(negedge clk) begin
    if (!rst2) begin
      if (fs2) begin
        if (fall2) sd = tx_sh[31];
        tx_sh = WORD_L;
        lb_q.push_back({1'b0, WORD_L});
      end else if (fall2) begin
        sd    = tx_sh[31];
        tx_sh = tx_sh << 1;
        if (lrck2 != tx_prev) begin
          tx_sh = WORD_R;
          lb_q.push_back({1'b1, WORD_R});
        end
      end
      if (fs2 || fall2) tx_prev = lrck2;
      if (rise2) begin
        rx_sh = {rx_sh[30:0], sd};
        if (lrck2 != rx_prev) begin
          if (lb_q.size() == 0) begin
            check("loopback_queue", 64'(lb_q.size()), 64'd1);
          end else begin
            lb_exp = lb_q.pop_front();
            check("loopback_word", 64'({rx_prev, rx_sh}), 64'(lb_exp));
          end
          lb_words++;
        end
        rx_prev = lrck2;
      end
    end
  end

  // Stimulus.
  initial begin
    int guard;
    logic [15:0] fc_before;
    rst = 1'b1; rst2 = 1'b1; enable = 1'b0; div = 8'd0;
    #1;
    check("reset_state", 64'({sclk, lrck, rise, fall, fs, running, fcnt}),
          64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;

    // Idle with enable low: nothing moves, whatever div_in does.
    for (int i = 0; i < 6; i++) tick(0, $urandom_range(0, 7));

    // Enable held, div=1: 4-clk SCLK, 32-clk frames.
    for (int i = 0; i < 100; i++) tick(1, 1);

    // div=0 requested: takes effect at the next boundary, 16-clk frames.
    for (int i = 0; i < 60; i++) tick(1, 0);

    // Align to a frame with div=1, then change div to 3 at clk 5.
    guard = 0;
    while (!(fs && m_h == 2) && guard < 200) begin tick(1, 1); guard++; end
    check("align_div1_frame", 64'(guard < 200), 64'd1);
    for (int i = 0; i < 4; i++) tick(1, 1);
    for (int i = 0; i < 120; i++) tick(1, 3);

    // Back to div=1, find a frame start, dip enable inside the frame and
    // raise it again: frames must continue without a gap.
    guard = 0;
    do begin tick(1, 1); guard++; end while (!(fs && m_h == 2) && guard < 200);
    check("align_stop_frame", 64'(guard < 200), 64'd1);
    for (int i = 0; i < 6; i++) tick(1, 1);
    for (int i = 0; i < 3; i++) tick(0, 1);
    for (int i = 0; i < 40; i++) tick(1, 1);

    // Drop enable in the right slot and let the frame run out to IDLE.
    guard = 0;
    do begin tick(1, 1); guard++; end while (!(fs && m_h == 2) && guard < 200);
    for (int i = 0; i < 19; i++) tick(1, 1);
    fc_before = fcnt;
    guard = 0;
    while (running && guard < 100) begin tick(0, 2); guard++; end
    check("stop_reaches_idle", 64'(guard < 100), 64'd1);
    check("stop_keeps_count", 64'(fcnt), 64'(fc_before));
    for (int i = 0; i < 5; i++) tick(0, 1);

    // Randomised enable dips and div changes.
    for (int i = 0; i < 500; i++)
      tick($urandom_range(0, 15) != 0, $urandom_range(0, 3));

    // Asynchronous reset mid-frame, checked before any clk edge.
    for (int i = 0; i < 3; i++) tick(1, 1);
    for (int i = 0; i < 11; i++) tick(1, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 64'({sclk, lrck, rise, fall, fs, running, fcnt}),
          64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}));
    exp_q.delete();
    m_active = 0; m_fc = '0; m_t = 0; m_stop = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) tick(1, 1);

    // Let the loopback collect enough words.
    guard = 0;
    while (lb_words < 6 && guard < 4000) begin @(negedge clk); guard++; end
    check("loopback_words", 64'(lb_words >= 6), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
